// File: rtl/ring_pkg.sv
// Shared ring-pattern definitions: FSM states plus the rotate/one-hot helpers that
// both the generator and the receiver use, so the two ends agree on direction.
package ring_pkg;

  localparam int RING_MAX_W = 32;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} ring_state_t;

  // Vectors are zero-extended to RING_MAX_W; n is the live pattern width.
  function automatic logic [RING_MAX_W-1:0] ring_mask(input int n);
    return (n >= RING_MAX_W) ? '1 : ((RING_MAX_W'(1) << n) - RING_MAX_W'(1));
  endfunction

  // Bit i moves to bit i+1; the top live bit wraps to bit 0.
  function automatic logic [RING_MAX_W-1:0] rotl(input logic [RING_MAX_W-1:0] x, input int n);
    logic [RING_MAX_W-1:0] xm;
    xm = x & ring_mask(n);
    return ((xm << 1) | (xm >> (n - 1))) & ring_mask(n);
  endfunction

  function automatic logic onehot(input logic [RING_MAX_W-1:0] x, input int n);
    logic [RING_MAX_W-1:0] xm;
    xm = x & ring_mask(n);
    return (xm != '0) && ((xm & (xm - RING_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_sync.sv
// N-bit two-flop synchroniser for the asynchronous ring pins.
module ring_sync #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ring_rx.sv
// Ring-pattern receiver: synchronises the pins, hunts for phase, locks after a run of
// matches, then pulses o_err and counts (saturating) every sample breaking the rotation.
module ring_rx
  import ring_pkg::*;
#(
  parameter int N           = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [N-1:0]     i_i,
  input  logic             i_en,
  input  logic             i_clr,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_errcnt
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

  logic [N-1:0]       w_s;
  logic [N-1:0]       w_rot_s;
  logic [N-1:0]       w_rot_e;
  logic               w_s_onehot;
  logic               w_match;

  ring_state_t        r_state;
  logic [N-1:0]       r_exp;
  logic [MATCH_W-1:0] r_matches;
  logic [MISS_W-1:0]  r_misses;
  logic               r_locked;
  logic               r_err;
  logic [CNT_W-1:0]   r_errcnt;

  ring_sync #(.W(N)) u_sync (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_d      (i_i),
    .o_q      (w_s)
  );

  assign w_rot_s    = N'(rotl(RING_MAX_W'(w_s), N));
  assign w_rot_e    = N'(rotl(RING_MAX_W'(r_exp), N));
  assign w_s_onehot = onehot(RING_MAX_W'(w_s), N);
  assign w_match    = (w_s == r_exp);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= HUNT;
      r_exp     <= '0;
      r_matches <= '0;
      r_misses  <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_errcnt  <= '0;
    end else begin
      r_err <= 1'b0;
      if (i_en) begin
        case (r_state)
          HUNT: begin
            if (w_s_onehot) begin
              r_exp     <= w_rot_s;
              r_matches <= '0;
              r_state   <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_exp <= w_rot_e;
              if (r_matches == MATCH_W'(LOCK_COUNT - 1)) begin
                r_matches <= '0;
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
              end else begin
                r_matches <= r_matches + 1'b1;
              end
            end else begin
              r_matches <= '0;
              r_state   <= HUNT;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_exp    <= w_rot_e;
              r_misses <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_errcnt != '1) r_errcnt <= r_errcnt + 1'b1;
              // Resync on a clean one-hot sample so a single slipped phase costs one error.
              r_exp <= w_s_onehot ? w_rot_s : w_rot_e;
              if (r_misses == MISS_W'(UNLOCK_ERRS - 1)) begin
                r_misses <= '0;
                r_state  <= HUNT;
                r_locked <= 1'b0;
              end else begin
                r_misses <= r_misses + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
        // Clear overrides a same-cycle increment; the error pulse above is kept.
        if (i_clr) r_errcnt <= '0;
      end
    end
  end

  assign o_locked = r_locked;
  assign o_err    = r_err;
  assign o_errcnt = r_errcnt;

endmodule

// File: tb/tb_ring_rx.sv
// Bench for ring_rx: a hand-computed lock table, directed corner sequences and a
// randomized run, all checked each cycle against a bit-position reference model.
module tb_ring_rx;

  localparam int N   = 2;
  localparam int LC  = 4;
  localparam int UE  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          en;
  logic          clr;
  logic [N-1:0]  din;
  logic          locked;
  logic          err;
  logic [CW-1:0] errcnt;

  always #5 clk = ~clk;

  ring_rx #(.N(N), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .CNT_W(CW)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_i      (din),
    .i_en     (en),
    .i_clr    (clr),
    .o_locked (locked),
    .o_err    (err),
    .o_errcnt (errcnt)
  );

  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";

  // Reference model: sync pipe as two samples, mode 0=hunt 1=verify 2=locked.
  int m_meta, m_s, m_exp, m_mode, m_match, m_miss, m_cnt;
  bit m_err;

  bit [N-1:0] pat;

  function automatic int rot(int x);
    int y = 0;
    for (int p = 0; p < N; p++)
      if (((x >> p) & 1) != 0) y = y + (1 << ((p + 1) % N));
    return y;
  endfunction

  function automatic bit is_onehot(int x);
    return $countones(x) == 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0d want %0d", phase, name, act, exp);
    end
  endtask

  task automatic model_edge(bit rn, bit e, bit c, int d);
    if (!rn) begin
      m_meta = 0; m_s = 0; m_exp = 0; m_mode = 0;
      m_match = 0; m_miss = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (e) begin
        if (m_mode == 0) begin
          if (is_onehot(m_s)) begin m_exp = rot(m_s); m_match = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (m_s == m_exp) begin
            m_exp = rot(m_exp);
            m_match++;
            if (m_match == LC) begin m_mode = 2; m_match = 0; end
          end else begin
            m_mode = 0; m_match = 0;
          end
        end else begin
          if (m_s == m_exp) begin
            m_exp = rot(m_exp); m_miss = 0;
          end else begin
            m_err = 1;
            m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
            m_exp = is_onehot(m_s) ? rot(m_s) : rot(m_exp);
            m_miss++;
            if (m_miss == UE) begin m_mode = 0; m_miss = 0; end
          end
        end
        if (c) m_cnt = 0;
      end
      m_s = m_meta;
      m_meta = d;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(bit rn, bit e, bit c, int d);
    resetn = rn; en = e; clr = c; din = N'(d);
    @(posedge clk);
    model_edge(rn, e, c, d);
    #1;
    chk("locked", 32'(locked), 32'(m_mode == 2));
    chk("err", 32'(err), 32'(m_err));
    chk("errcnt", 32'(errcnt), 32'(m_cnt));
  endtask

  task automatic good(int n);
    for (int k = 0; k < n; k++) begin
      step(1, 1, 0, int'(pat));
      pat = N'(rot(int'(pat)));
    end
  endtask

  task automatic bad(int v);
    step(1, 1, 0, v);
    pat = N'(rot(int'(pat)));
  endtask

  typedef struct {
    bit         rn;
    bit [N-1:0] d;
    bit         lk;
    bit         er;
    int         cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int pulses;
    bit seen;

    tbl = '{
      '{1'b0, 2'b01, 1'b0, 1'b0, 0},
      '{1'b1, 2'b01, 1'b0, 1'b0, 0},
      '{1'b1, 2'b10, 1'b0, 1'b0, 0},
      '{1'b1, 2'b01, 1'b0, 1'b0, 0},
      '{1'b1, 2'b10, 1'b0, 1'b0, 0},
      '{1'b1, 2'b01, 1'b0, 1'b0, 0},
      '{1'b1, 2'b10, 1'b0, 1'b0, 0},
      '{1'b1, 2'b01, 1'b1, 1'b0, 0},
      '{1'b1, 2'b10, 1'b1, 1'b0, 0},
      '{1'b1, 2'b01, 1'b1, 1'b0, 0}
    };
    resetn = 1'b0; en = 1'b1; clr = 1'b0; din = '0;
    m_meta = 0; m_s = 0; m_exp = 0; m_mode = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_err = 0;

    // Reset and lock acquisition against hand-derived expectations.
    phase = "t1_lock";
    for (int r = 0; r < 10; r++) begin
      step(tbl[r].rn, 1, 0, int'(tbl[r].d));
      chk("tbl_locked", 32'(locked), 32'(tbl[r].lk));
      chk("tbl_err", 32'(err), 32'(tbl[r].er));
      chk("tbl_errcnt", 32'(errcnt), 32'(tbl[r].cnt));
    end
    pat = 2'b10;

    // Single 00 sample while locked.
    phase = "t2_single";
    good(4);
    bad(0);
    pulses = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin
      good(1);
      pulses += int'(err);
      if (!locked) seen = 1;
    end
    chk("pulses", 32'(pulses), 1);
    chk("errcnt", 32'(errcnt), 1);
    chk("lock_lost", 32'(seen), 0);

    // Two 11 samples drop lock, then relock.
    phase = "t3_unlock";
    bad(3); bad(3);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      good(1);
      if (!locked) seen = 1;
    end
    chk("unlocked", 32'(seen), 1);
    chk("errcnt", 32'(errcnt), 3);
    good(12);
    chk("relocked", 32'(locked), 1);

    // Constant 01 never locks.
    phase = "t4_const";
    step(0, 1, 0, 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 1);
      if (locked) seen = 1;
    end
    chk("ever_locked", 32'(seen), 0);
    chk("errcnt", 32'(errcnt), 0);

    // EN=0 while locked with corrupt input freezes everything.
    phase = "t4_freeze";
    pat = 2'b01;
    good(12);
    chk("locked_pre", 32'(locked), 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0);
      if (err || !locked || errcnt != 0) seen = 1;
    end
    chk("frozen_bad", 32'(seen), 0);
    good(4);

    // Saturation at 15 and CLR against a same-cycle error.
    phase = "t5_sat";
    step(0, 1, 0, 0);
    pat = 2'b01;
    good(12);
    for (int k = 0; k < 20; k++) begin
      bad(0);
      good(5);
    end
    chk("sat", 32'(errcnt), 15);
    chk("locked", 32'(locked), 1);
    bad(0);
    good(1);
    step(1, 1, 1, int'(pat));
    pat = N'(rot(int'(pat)));
    chk("clr_err", 32'(err), 1);
    chk("clr_cnt", 32'(errcnt), 0);
    good(4);

    // Reset mid-operation with ERRCNT=5.
    phase = "t6_reset";
    step(0, 1, 0, 0);
    pat = 2'b01;
    good(12);
    for (int k = 0; k < 5; k++) begin
      bad(0);
      good(4);
    end
    chk("cnt5", 32'(errcnt), 5);
    step(0, 1, 0, int'(pat));
    pat = N'(rot(int'(pat)));
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(errcnt), 0);

    // Randomized run against the model.
    phase = "rand";
    for (int k = 0; k < 3000; k++) begin
      bit rn, e, c;
      int d;
      rn = ($urandom_range(0, 399) != 0);
      e  = ($urandom_range(0, 15) != 0);
      c  = ($urandom_range(0, 49) == 0);
      d  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, (1 << N) - 1)) : int'(pat);
      if ($urandom_range(0, 99) == 0) pat = N'(rot(int'(pat)));
      step(rn, e, c, d);
      pat = N'(rot(int'(pat)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
